// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory with per-byte write enables, registered read,
// valid/ready handshake and a sequencer that zeroes the array after reset or on request.
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    write_en,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    clear,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    addr_err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(DEPTH);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept, in_range, last;
    logic [CW-1:0]         idx;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    // one extra bit so DEPTH == 2^ADDR_WIDTH still compares correctly
    assign in_range  = {1'b0, addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign idx       = addr[CW-1:0];
    assign last      = (cnt == CW'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (state == CLEAR) begin
            state_nxt = last ? IDLE : CLEAR;
            cnt_nxt   = last ? '0 : cnt + 1'b1;
        end else if (clear) begin
            state_nxt = CLEAR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept && write_en && in_range) begin
            for (int i = 0; i < NB; i++)
                if (byte_en[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            data_out <= '0;
        end else begin
            rd_valid <= accept & ~write_en;
            addr_err <= accept & ~in_range;
            if (accept && !write_en) data_out <= in_range ? mem[idx] : '0;
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: randomized and directed checks of data_memory_ctrl against an array model.
module tb_data_memory_ctrl;
    logic        clk = 0, rst = 1, req_valid = 0, write_en = 0, clear = 0;
    logic [1:0]  byte_en = 0;
    logic [15:0] addr = 0, data_in = 0;
    logic        req_ready, rd_valid, addr_err;
    logic [15:0] data_out;

    int          total = 0, bad = 0;
    logic [15:0] mdl [256];
    logic [15:0] last_rd = 0;

    data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .write_en(write_en), .byte_en(byte_en), .addr(addr), .data_in(data_in),
        .clear(clear), .rd_valid(rd_valid), .data_out(data_out), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0;
    endtask

    // drives one request at the falling edge; returns 1 time unit after the accepting edge
    task automatic access(input logic we, input logic [1:0] be, input int a, input logic [15:0] d);
        @(negedge clk);
        req_valid = 1; write_en = we; byte_en = be; addr = a[15:0]; data_in = d;
        @(posedge clk); #1;
        if (a < 256 && we) begin
            if (be[0]) mdl[a][7:0]  = d[7:0];
            if (be[1]) mdl[a][15:8] = d[15:8];
        end
        if (!we) last_rd = (a < 256) ? mdl[a] : 16'h0;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 0; write_en = 0;
    endtask

    // counts rising edges until req_ready, optionally pulsing clear after edge pulse_at
    task automatic wait_ready(input int pulse_at, output int n);
        n = 0;
        while (n < 2000) begin
            clear = (n == pulse_at);
            @(posedge clk); #1;
            clear = 0;
            n++;
            if (req_ready) break;
        end
    endtask

    task automatic check_read(input string name, input int a);
        logic [15:0] exp;
        exp = (a < 256) ? mdl[a] : 16'h0;
        total++;
        if (rd_valid !== 1'b1 || data_out !== exp || addr_err !== (a >= 256)) begin
            bad++;
            $display("FAIL %s addr=%0d: rd_valid=%b data_out=%h addr_err=%b, want 1 %h %b",
                     name, a, rd_valid, data_out, addr_err, exp, a >= 256);
        end
    endtask

    task automatic check_write(input string name, input int a);
        total++;
        if (rd_valid !== 1'b0 || addr_err !== (a >= 256) || data_out !== last_rd) begin
            bad++;
            $display("FAIL %s addr=%0d: rd_valid=%b addr_err=%b data_out=%h, want 0 %b %h",
                     name, a, rd_valid, addr_err, data_out, a >= 256, last_rd);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 0 || rd_valid !== 0 || data_out !== 0 || addr_err !== 0) begin
            bad++;
            $display("FAIL reset_outputs: %b %b %h %b, want all 0", req_ready, rd_valid, data_out, addr_err);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        wait_ready(-1, n);
        total++;
        if (n !== 256) begin bad++; $display("FAIL reset_clear_len: %0d edges, want 256", n); end
        access(0, 2'b11, 2, 0);
        check_read("reset_read2", 2);
        idle();
    endtask

    task automatic test_write_read();
        int a [3] = '{2, 5, 10};
        int d [3] = '{25, 50, 250};
        for (int i = 0; i < 3; i++) begin
            access(1, 2'b11, a[i], d[i][15:0]);
            check_write("wr_basic", a[i]);
        end
        for (int i = 0; i < 3; i++) begin
            access(0, 2'b11, a[i], 0);
            check_read("b2b_read", a[i]);
            total++;
            if (data_out !== d[i][15:0]) begin
                bad++; $display("FAIL b2b_value: got %h want %h", data_out, d[i][15:0]);
            end
        end
        access(1, 2'b11, 3, 16'h1234);
        check_write("wr_1234", 3);
        access(0, 2'b11, 3, 0);
        check_read("raw_read3", 3);
        idle();
        @(posedge clk); #1;
        total++;
        if (rd_valid !== 0) begin bad++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_byte_en();
        access(1, 2'b11, 7, 16'hABCD);
        access(1, 2'b10, 7, 16'h1200);
        access(0, 2'b00, 7, 0);
        check_read("byte_en_read7", 7);
        total++;
        if (data_out !== 16'h12CD) begin bad++; $display("FAIL byte_en_value: got %h want 12cd", data_out); end
        idle();
    endtask

    task automatic test_out_of_range();
        access(1, 2'b11, 300, 16'hFFFF);
        check_write("oor_write", 300);
        idle();
        @(posedge clk); #1;
        total++;
        if (addr_err !== 0) begin bad++; $display("FAIL addr_err_pulse: got %b want 0", addr_err); end
        access(0, 2'b11, 44, 0);
        check_read("oor_alias44", 44);
        access(0, 2'b11, 300, 0);
        check_read("oor_read300", 300);
        idle();
    endtask

    task automatic test_clear();
        int n;
        @(negedge clk);
        req_valid = 1; write_en = 0; addr = 5; clear = 1;
        @(posedge clk); #1;
        last_rd = mdl[5];
        total++;
        if (rd_valid !== 1 || data_out !== 16'd50 || req_ready !== 0) begin
            bad++; $display("FAIL clear_with_read: rd_valid=%b data_out=%h req_ready=%b, want 1 0032 0",
                            rd_valid, data_out, req_ready);
        end
        clear = 0; req_valid = 0;
        model_clear();
        wait_ready(50, n);
        total++;
        if (n !== 256) begin bad++; $display("FAIL clear_len: %0d edges, want 256", n); end
        access(0, 2'b11, 2, 0);  check_read("cleared2", 2);
        access(0, 2'b11, 5, 0);  check_read("cleared5", 5);
        access(0, 2'b11, 10, 0); check_read("cleared10", 10);
        idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            int          a;
            logic        we;
            logic [1:0]  be;
            logic [15:0] d;
            a  = $urandom_range(0, 299);
            if (k % 3 == 0) a = $urandom_range(0, 15);
            we = 1'($urandom);
            be = 2'($urandom);
            d  = 16'($urandom);
            access(we, be, a, d);
            if (we) check_write("rand_write", a);
            else    check_read("rand_read", a);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk); #1;
                total++;
                if (rd_valid !== 0 || addr_err !== 0) begin
                    bad++; $display("FAIL rand_idle: rd_valid=%b addr_err=%b want 0 0", rd_valid, addr_err);
                end
            end
        end
        for (int a = 0; a < 16; a++) begin
            access(0, 2'b00, a, 0);
            check_read("rand_sweep", a);
        end
        idle();
    endtask

    task automatic test_async_reset();
        int n;
        access(1, 2'b11, 9, 16'hBEEF);
        access(0, 2'b11, 9, 0);
        idle();
        @(negedge clk);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        repeat (100) @(posedge clk);
        #3;
        total++;
        if (data_out !== 16'hBEEF) begin bad++; $display("FAIL hold_in_clear: got %h want beef", data_out); end
        rst = 1;
        #1;
        total++;
        if (req_ready !== 0 || rd_valid !== 0 || data_out !== 0 || addr_err !== 0) begin
            bad++; $display("FAIL async_reset: %b %b %h %b, want all 0", req_ready, rd_valid, data_out, addr_err);
        end
        @(negedge clk);
        rst = 0;
        model_clear();
        last_rd = 0;
        wait_ready(-1, n);
        total++;
        if (n !== 256) begin bad++; $display("FAIL reset_mid_clear_len: %0d edges, want 256", n); end
        access(0, 2'b11, 9, 0);
        check_read("after_reset9", 9);
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_en();
        test_out_of_range();
        test_clear();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
